// File: rtl/seg_codes_pkg.sv
// Shared definitions for the 6-digit multiplexed 7-segment scan bus:
// segment patterns (active-low, bit7 = point), display codes and the
// digit-select to display-index mapping.
package seg_codes_pkg;

   localparam int NUM_DIGITS = 6;

   typedef logic [4:0] code_t;
   typedef logic [5:0] sel_t;
   typedef logic [7:0] pat_t;

   // Active-low segment patterns with the point segment off (bit7 = 1)
   localparam pat_t PAT_0    = 8'hC0;
   localparam pat_t PAT_1    = 8'hF9;
   localparam pat_t PAT_2    = 8'hA4;
   localparam pat_t PAT_3    = 8'hB0;
   localparam pat_t PAT_4    = 8'h99;
   localparam pat_t PAT_5    = 8'h92;
   localparam pat_t PAT_6    = 8'h82;
   localparam pat_t PAT_7    = 8'hF8;
   localparam pat_t PAT_8    = 8'h80;
   localparam pat_t PAT_9    = 8'h90;
   localparam pat_t PAT_DASH = 8'hBF;
   localparam pat_t PAT_C    = 8'hC6;
   localparam pat_t PAT_H    = 8'h89;
   localparam pat_t PAT_DARK = 8'hFF;

   // AND-ing a digit pattern with this lights the decimal point
   localparam pat_t POINT_MASK = 8'h7f;

   localparam code_t CODE_POINT_OFS = 5'd10;
   localparam code_t CODE_DASH      = 5'd20;
   localparam code_t CODE_C         = 5'd21;
   localparam code_t CODE_H         = 5'd22;
   localparam code_t CODE_DARK      = 5'd31;

   // Digit 1 is driven by sel bit5, digit 6 by sel bit0
   function automatic logic [2:0] sel_to_index(input sel_t sel);
      logic [2:0] idx;
      idx = 3'd0;
      case (sel)
         6'b100000: idx = 3'd0;
         6'b010000: idx = 3'd1;
         6'b001000: idx = 3'd2;
         6'b000100: idx = 3'd3;
         6'b000010: idx = 3'd4;
         6'b000001: idx = 3'd5;
         default:   idx = 3'd0;
      endcase
      return idx;
   endfunction

   function automatic logic sel_is_onehot(input sel_t sel);
      return (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
   endfunction

endpackage

// File: rtl/seg_pattern_to_code.sv
// Combinational decoder from an active-low segment pattern to a display code.
// Digits 0-9 decode with or without the point; dash, C, H and dark only
// decode with the point off. Anything else is reported as unknown.
module seg_pattern_to_code
   import seg_codes_pkg::*;
(
   input  logic [7:0] pattern,
   output code_t      code,
   output logic       known
);

   logic [3:0] digit;
   logic       digit_known;

   // Look up the digit value with the point segment forced off
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      digit       = 4'd0;
      digit_known = 1'b1;
      case (pattern | ~POINT_MASK)
         PAT_0:   digit = 4'd0;
         PAT_1:   digit = 4'd1;
         PAT_2:   digit = 4'd2;
         PAT_3:   digit = 4'd3;
         PAT_4:   digit = 4'd4;
         PAT_5:   digit = 4'd5;
         PAT_6:   digit = 4'd6;
         PAT_7:   digit = 4'd7;
         PAT_8:   digit = 4'd8;
         PAT_9:   digit = 4'd9;
         default: digit_known = 1'b0;
      endcase
   end

   // Symbols match exactly; digits add 10 when the point (bit7 low) is lit
   always_comb begin
      code  = CODE_DARK;
      known = 1'b1;
      case (pattern)
         PAT_DASH: code = CODE_DASH;
         PAT_C:    code = CODE_C;
         PAT_H:    code = CODE_H;
         PAT_DARK: code = CODE_DARK;
         default: begin
            known = digit_known;
            code  = pattern[7] ? {1'b0, digit} : ({1'b0, digit} + CODE_POINT_OFS);
         end
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive scan-bus receiver: synchronizes the segment/select bus, waits for
// it to settle, decodes each captured digit into dis1..dis6 and reports
// frame completion, loss of scan activity and illegal bus contents.
module seg_scan_decoder
   import seg_codes_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seg_in,
   input  logic [5:0] sel_in,
   output code_t      dis1,
   output code_t      dis2,
   output code_t      dis3,
   output code_t      dis4,
   output code_t      dis5,
   output code_t      dis6,
   output logic       frame_done,
   output logic       frame_valid,
   output logic       stale,
   output logic       code_err
);

   localparam logic [13:0] BUS_IDLE     = {PAT_DARK, 6'b000000};
   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
   localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES);

   logic [13:0] bus_s1, bus_s2, bus_q;
   logic        change;
   logic [15:0] settle_cnt, settle_nxt;
   logic        armed, capture;

   pat_t        seg_cap;
   sel_t        sel_cap;
   code_t       dec_code;
   logic        dec_known;
   logic        sel_onehot;
   logic [2:0]  sel_idx;
   logic        valid_cap, bad_cap;

   sel_t        seen_mask, mask_merged;
   logic [23:0] tmo_cnt, tmo_nxt;
   logic        expire;
   code_t       dis_q [NUM_DIGITS];

   // Two-flop synchronizer plus a history register for change detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_s1 <= BUS_IDLE;
         bus_s2 <= BUS_IDLE;
         bus_q  <= BUS_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         bus_s1 <= {seg_in, sel_in};
         bus_s2 <= bus_s1;
         bus_q  <= bus_s2;
      end
   end

   assign change  = (bus_s2 != bus_q);
   assign seg_cap = bus_s2[13:6];
   assign sel_cap = bus_s2[5:0];

   // Settle counter: a change restarts it, capture fires once it reaches SETTLE-1
   always_comb begin
      settle_nxt = 16'd0;
      if (!change) begin
         settle_nxt = (settle_cnt == 16'hFFFF) ? settle_cnt : settle_cnt + 16'd1;
      end
      capture = (change || armed) && (settle_nxt == SETTLE_LAST);
   end

   // Settle counter and arm flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_cnt <= 16'd0;
         armed      <= 1'b0;
      end else begin
         settle_cnt <= settle_nxt;
         armed      <= (change || armed) && !capture;
      end
   end

   seg_pattern_to_code u_decode (
      .pattern (seg_cap),
      .code    (dec_code),
      .known   (dec_known)
   );

   // Classify the capture and precompute the frame and timeout updates
   always_comb begin
      sel_onehot  = sel_is_onehot(sel_cap);
      sel_idx     = sel_to_index(sel_cap);
      valid_cap   = capture && sel_onehot && dec_known;
      bad_cap     = capture && (sel_cap != 6'd0) && !(sel_onehot && dec_known);
      mask_merged = seen_mask | sel_cap;
      tmo_nxt     = (tmo_cnt == 24'hFFFFFF) ? tmo_cnt : tmo_cnt + 24'd1;
      expire      = (tmo_nxt == TIMEOUT_LAST);
   end

   // Display registers, frame tracking, timeout and status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: dis_q is a six-entry register bank, not a RAM, so it can take a reset value (dark).
         for (int i = 0; i < NUM_DIGITS; i++) dis_q[i] <= CODE_DARK;
         seen_mask   <= 6'd0;
         tmo_cnt     <= 24'd0;
         frame_done  <= 1'b0;
         frame_valid <= 1'b0;
         stale       <= 1'b0;
         code_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         code_err   <= bad_cap;
         if (valid_cap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (i[2:0] == sel_idx) dis_q[i] <= dec_code;
            end
            tmo_cnt <= 24'd0;
            stale   <= 1'b0;
            if (mask_merged == 6'b111111) begin
               seen_mask   <= 6'd0;
               frame_done  <= 1'b1;
               frame_valid <= 1'b1;
            end else begin
               seen_mask <= mask_merged;
            end
         end else begin
            tmo_cnt <= tmo_nxt;
            if (expire) begin
               stale       <= 1'b1;
               frame_valid <= 1'b0;
               seen_mask   <= 6'd0;
            end
         end
      end
   end

   assign dis1 = dis_q[0];
   assign dis2 = dis_q[1];
   assign dis3 = dis_q[2];
   assign dis4 = dis_q[3];
   assign dis5 = dis_q[4];
   assign dis6 = dis_q[5];

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a decode vector table plus hand
// sequences for latency, full frames, glitches, timeout and async reset.
module tb_seg_scan_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] seg_in;
   logic [5:0] sel_in;
   logic [4:0] dis1, dis2, dis3, dis4, dis5, dis6;
   logic       frame_done, frame_valid, stale, code_err;

   logic [4:0] dis_a [6];
   int         total = 0;
   int         bad   = 0;
   int         err_pulses = 0;
   int         fd_pulses  = 0;
   int         e0, f0;

   typedef struct {
      logic [7:0] seg;
      logic [5:0] sel;
      int         idx;
      int         exp_code;
      int         exp_err;
   } vec_t;

   vec_t vecs [19];

   seg_scan_decoder #(
      .SETTLE_CYCLES  (16),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .sel_in      (sel_in),
      .dis1        (dis1),
      .dis2        (dis2),
      .dis3        (dis3),
      .dis4        (dis4),
      .dis5        (dis5),
      .dis6        (dis6),
      .frame_done  (frame_done),
      .frame_valid (frame_valid),
      .stale       (stale),
      .code_err    (code_err)
   );

   always #5 clk = ~clk;

   always_comb begin
      dis_a[0] = dis1;
      dis_a[1] = dis2;
      dis_a[2] = dis3;
      dis_a[3] = dis4;
      dis_a[4] = dis5;
      dis_a[5] = dis6;
   end

   // Count single-cycle pulses away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (code_err)   err_pulses++;
         if (frame_done) fd_pulses++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] s, input logic [5:0] d);
      seg_in = s;
      sel_in = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(8'hFF, 6'b000000);
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      // seg, sel, display index, expected code, expected code_err pulses
      vecs[0]  = '{8'hC0, 6'b100000, 0,  0, 0};
      vecs[1]  = '{8'hF9, 6'b010000, 1,  1, 0};
      vecs[2]  = '{8'h24, 6'b001000, 2, 12, 0};
      vecs[3]  = '{8'hBF, 6'b000100, 3, 20, 0};
      vecs[4]  = '{8'hC6, 6'b000010, 4, 21, 0};
      vecs[5]  = '{8'h89, 6'b000001, 5, 22, 0};
      vecs[6]  = '{8'h00, 6'b000001, 5, 18, 0};
      vecs[7]  = '{8'h3F, 6'b000001, 5, 18, 1};
      vecs[8]  = '{8'h10, 6'b000001, 5, 19, 0};
      vecs[9]  = '{8'hFF, 6'b100000, 0, 31, 0};
      vecs[10] = '{8'h12, 6'b100000, 0, 15, 0};
      vecs[11] = '{8'h55, 6'b010000, 1,  1, 1};
      vecs[12] = '{8'hC0, 6'b011000, 1,  1, 1};
      vecs[13] = '{8'h00, 6'b000000, 1,  1, 0};
      vecs[14] = '{8'h78, 6'b000100, 3, 17, 0};
      vecs[15] = '{8'h82, 6'b000010, 4,  6, 0};
      vecs[16] = '{8'h99, 6'b001000, 2,  4, 0};
      vecs[17] = '{8'hB0, 6'b010000, 1,  3, 0};
      vecs[18] = '{8'h80, 6'b100000, 0,  8, 0};

      // Reset then idle
      do_reset();
      tick(30);
      for (int i = 0; i < 6; i++) check($sformatf("idle dis%0d", i + 1), dis_a[i], 31);
      check("idle frame_valid", frame_valid, 0);
      check("idle stale", stale, 0);
      check("idle code_err pulses", err_pulses, 0);
      check("idle frame_done pulses", fd_pulses, 0);

      // Capture latency: 18 cycles from the bus change
      e0 = err_pulses;
      drive(8'hA4, 6'b100000);
      tick(17);
      check("latency dis1 before", dis1, 31);
      tick(1);
      check("latency dis1 at 18", dis1, 2);
      tick(22);
      check("latency dis1 held", dis1, 2);
      check("latency code_err", err_pulses - e0, 0);

      // Decode table
      for (int i = 0; i < 19; i++) begin
         e0 = err_pulses;
         drive(vecs[i].seg, vecs[i].sel);
         tick(25);
         check($sformatf("vec%0d code", i), dis_a[vecs[i].idx], vecs[i].exp_code);
         check($sformatf("vec%0d code_err", i), err_pulses - e0, vecs[i].exp_err);
      end

      // Full six-digit scan, 1000 cycles per digit
      do_reset();
      f0 = fd_pulses;
      drive(8'hF9, 6'b100000); tick(1000);
      drive(8'hA4, 6'b010000); tick(1000);
      drive(8'h30, 6'b001000); tick(1000);
      drive(8'h99, 6'b000100); tick(1000);
      drive(8'h92, 6'b000010); tick(1000);
      drive(8'hFF, 6'b000001);
      tick(17);
      check("scan frame_done early", frame_done, 0);
      check("scan frame_valid early", frame_valid, 0);
      tick(1);
      check("scan frame_done", frame_done, 1);
      check("scan frame_valid", frame_valid, 1);
      check("scan dis1", dis1, 1);
      check("scan dis2", dis2, 2);
      check("scan dis3", dis3, 13);
      check("scan dis4", dis4, 4);
      check("scan dis5", dis5, 5);
      check("scan dis6", dis6, 31);
      tick(1);
      check("scan frame_done drop", frame_done, 0);
      check("scan frame_done pulses", fd_pulses - f0, 1);
      check("scan stale", stale, 0);

      // Bus frozen: stale after 1000 cycles from the last capture
      tick(998);
      check("timeout stale before", stale, 0);
      check("timeout frame_valid before", frame_valid, 1);
      tick(1);
      check("timeout stale", stale, 1);
      check("timeout frame_valid", frame_valid, 0);
      check("timeout dis1 held", dis1, 1);
      drive(8'hC0, 6'b100000);
      tick(17);
      check("recover stale before", stale, 1);
      tick(1);
      check("recover stale", stale, 0);
      check("recover dis1", dis1, 0);
      check("recover frame_valid", frame_valid, 0);

      // Short glitch is filtered, held unknown pattern flags once
      drive(8'hC0, 6'b001000);
      tick(40);
      check("glitch dis3 base", dis3, 0);
      e0 = err_pulses;
      drive(8'h00, 6'b001000);
      tick(5);
      drive(8'hC0, 6'b001000);
      tick(40);
      check("glitch dis3", dis3, 0);
      check("glitch code_err", err_pulses - e0, 0);
      e0 = err_pulses;
      drive(8'h55, 6'b001000);
      tick(40);
      check("unknown code_err", err_pulses - e0, 1);
      check("unknown dis3", dis3, 0);

      // Multi-hot select
      e0 = err_pulses;
      drive(8'hC0, 6'b110000);
      tick(40);
      check("multihot code_err", err_pulses - e0, 1);
      check("multihot dis1", dis1, 0);
      check("multihot dis2", dis2, 2);

      // Async reset in the middle of a settle window
      drive(8'h99, 6'b000100);
      tick(8);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) check($sformatf("rst dis%0d", i + 1), dis_a[i], 31);
      check("rst frame_done", frame_done, 0);
      check("rst frame_valid", frame_valid, 0);
      check("rst stale", stale, 0);
      check("rst code_err", code_err, 0);
      drive(8'hFF, 6'b000000);
      tick(2);
      rst = 1'b0;
      e0 = err_pulses;
      tick(30);
      check("post-rst dis4", dis4, 31);
      check("post-rst code_err", err_pulses - e0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
